// File: rtl/clint_port_arbiter_pkg.sv
// Shared types and CLINT map constants for the CLINT port arbiter.
// Optional macro: CLINT_ARB_LOCK_EN (locked back-to-back access for 64-bit pairs).
package clint_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_e;

    localparam logic [15:0] MSIP_BASE     = 16'h0000;
    localparam logic [15:0] MTIMECMP_BASE = 16'h4000;
    localparam logic [15:0] MTIME_LO      = 16'hBFF8;
    localparam logic [15:0] MTIME_HI      = 16'hBFFC;

    // Width of a requester index; at least one bit so N_REQ=1 stays legal.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/clint_port_arbiter_if.sv
// Requester-side and CLINT-side signals of the arbiter bundled in one interface.
interface clint_port_arbiter_if #(
    parameter int N_REQ    = 2,
    parameter int OFFSET_W = 16,
    parameter int DATA_W   = 32
);
    logic [N_REQ-1:0]          i_req;
    logic [N_REQ-1:0]          i_we;
    logic [N_REQ*OFFSET_W-1:0] i_offset;
    logic [N_REQ*DATA_W-1:0]   i_wdata;
    logic [N_REQ-1:0]          i_lock;
    logic [N_REQ-1:0]          o_ack;
    logic [DATA_W-1:0]         o_rdata;
    logic                      o_busy;
    logic [OFFSET_W-1:0]       o_clint_offset;
    logic                      o_clint_we;
    logic [DATA_W-1:0]         o_clint_wdata;
    logic [DATA_W-1:0]         i_clint_rdata;

    modport slave (
        input  i_req, i_we, i_offset, i_wdata, i_lock, i_clint_rdata,
        output o_ack, o_rdata, o_busy, o_clint_offset, o_clint_we, o_clint_wdata
    );

    modport master (
        output i_req, i_we, i_offset, i_wdata, i_lock, i_clint_rdata,
        input  o_ack, o_rdata, o_busy, o_clint_offset, o_clint_we, o_clint_wdata
    );
endinterface

// File: rtl/clint_port_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping.
module clint_rr_pick #(
    parameter int N_REQ = 2,
    parameter int IDX_W = 1
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N_REQ-1:0] grant,
    output logic [IDX_W-1:0] idx,
    output logic             any
);
    always_comb begin
        int k;
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        k     = 0;
        for (int i = 0; i < N_REQ; i++) begin
            k = (int'(ptr) + i) % N_REQ;
            if (!any && req[k]) begin
                grant[k] = 1'b1;
                idx      = IDX_W'(k);
                any      = 1'b1;
            end
        end
    end
endmodule

// File: rtl/clint_port_arbiter.sv
// Round-robin sequencer sharing the single CLINT register port between N_REQ requesters.
// Optional macro: CLINT_ARB_LOCK_EN keeps the port with a requester across a locked pair.
module clint_port_arbiter
    import clint_arb_pkg::*;
#(
    parameter int N_REQ    = 2,
    parameter int OFFSET_W = 16,
    parameter int DATA_W   = 32
) (
    input  logic               CLK,
    input  logic               RST,
    clint_port_arbiter_if.slave bus
);
    localparam int IDX_W = idx_width(N_REQ);

    state_e              state_q, state_d;
    logic [IDX_W-1:0]    ptr_q;
    logic [IDX_W-1:0]    idx_q;
    logic                we_q;
    logic [OFFSET_W-1:0] offset_q;
    logic [DATA_W-1:0]   wdata_q;

    logic [N_REQ-1:0]    elig;
    logic [N_REQ-1:0]    unused_grant;
    logic [IDX_W-1:0]    pick_idx;
    logic                pick_any;
    logic                accept;
    logic                advance;
    logic [N_REQ-1:0]    idx_oh;

    assign accept = (state_q == IDLE) && pick_any;
    assign idx_oh = N_REQ'(1) << idx_q;

`ifdef CLINT_ARB_LOCK_EN
    logic             lock_vld_q;
    logic [IDX_W-1:0] lock_own_q;
    logic             lock_req_q;

    // While locked only the owner may win, so the pair reaches the CLINT back to back.
    assign elig    = lock_vld_q ? (bus.i_req & (N_REQ'(1) << lock_own_q)) : bus.i_req;
    assign advance = !lock_req_q;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            lock_vld_q <= 1'b0;
            lock_own_q <= '0;
            lock_req_q <= 1'b0;
        end else begin
            if (accept)
                lock_req_q <= bus.i_lock[pick_idx];
            if (state_q == RESP) begin
                lock_vld_q <= lock_req_q;
                lock_own_q <= idx_q;
            end
        end
    end
`else
    logic unused_lock;

    assign elig        = bus.i_req;
    assign advance     = 1'b1;
    assign unused_lock = ^bus.i_lock;
`endif

    clint_rr_pick #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_pick (
        .req   (elig),
        .ptr   (ptr_q),
        .grant (unused_grant),
        .idx   (pick_idx),
        .any   (pick_any)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (pick_any) state_d = ISSUE;
            ISSUE:   state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Accept stage: latch the winner so its payload may change after acceptance.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q  <= IDLE;
            ptr_q    <= '0;
            idx_q    <= '0;
            we_q     <= 1'b0;
            offset_q <= '0;
            wdata_q  <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                idx_q    <= pick_idx;
                we_q     <= bus.i_we[pick_idx];
                offset_q <= bus.i_offset[int'(pick_idx)*OFFSET_W +: OFFSET_W];
                wdata_q  <= bus.i_wdata[int'(pick_idx)*DATA_W +: DATA_W];
            end
            if (state_q == RESP && advance)
                ptr_q <= (idx_q == IDX_W'(N_REQ-1)) ? '0 : idx_q + 1'b1;
        end
    end

    // Offset stays on the port through RESP so the CLINT's registered rdata matches it.
    assign bus.o_busy         = (state_q != IDLE);
    assign bus.o_clint_we     = (state_q == ISSUE) && we_q;
    assign bus.o_clint_offset = offset_q;
    assign bus.o_clint_wdata  = wdata_q;
    assign bus.o_ack          = (state_q == RESP) ? idx_oh : '0;
    assign bus.o_rdata        = (state_q == RESP && !we_q) ? bus.i_clint_rdata : '0;

endmodule

// File: tb/tb_clint_port_arbiter.sv
// Directed self-checking bench for clint_port_arbiter with a small registered CLINT model.
module tb_clint_port_arbiter;
    import clint_arb_pkg::*;

    localparam int N  = 2;
    localparam int OW = 16;
    localparam int DW = 32;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    clint_port_arbiter_if #(.N_REQ(N), .OFFSET_W(OW), .DATA_W(DW)) bus();

    clint_port_arbiter #(.N_REQ(N), .OFFSET_W(OW), .DATA_W(DW)) dut (
        .CLK (clk),
        .RST (rst),
        .bus (bus)
    );

    // CLINT model: registered read data, mtime counts every cycle
    logic [31:0] msip_r = 32'd0;
    logic [31:0] cmp_lo = 32'd0;
    logic [31:0] cmp_hi = 32'd0;
    logic [63:0] mtime  = 64'd100;
    logic [63:0] mtime_nx;
    assign mtime_nx = mtime + 64'd1;

    always @(posedge clk) begin
        mtime <= mtime_nx;
        if (bus.o_clint_we) begin
            case (bus.o_clint_offset)
                MSIP_BASE:             msip_r <= bus.o_clint_wdata;
                MTIMECMP_BASE:         cmp_lo <= bus.o_clint_wdata;
                MTIMECMP_BASE + 16'd4: cmp_hi <= bus.o_clint_wdata;
                default: ;
            endcase
        end
        case (bus.o_clint_offset)
            MSIP_BASE:             bus.i_clint_rdata <= msip_r;
            MTIMECMP_BASE:         bus.i_clint_rdata <= cmp_lo;
            MTIMECMP_BASE + 16'd4: bus.i_clint_rdata <= cmp_hi;
            MTIME_LO:              bus.i_clint_rdata <= mtime_nx[31:0];
            MTIME_HI:              bus.i_clint_rdata <= mtime_nx[63:32];
            default:               bus.i_clint_rdata <= 32'd0;
        endcase
    end

    typedef struct {
        int          k;
        logic        we;
        logic [15:0] off;
        logic [31:0] wd;
        logic [1:0]  ack;
        logic [31:0] rd;
    } vec_t;

    vec_t vecs[6];
    int   n_chk = 0;
    int   n_err = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic set_req(input int k, input logic r, input logic we, input logic lk,
                           input logic [15:0] off, input logic [31:0] wd);
        bus.i_req[k]             = r;
        bus.i_we[k]              = we;
        bus.i_lock[k]            = lk;
        bus.i_offset[k*OW +: OW] = off;
        bus.i_wdata[k*DW +: DW]  = wd;
    endtask

    task automatic wait_ack(output logic [1:0] a, output int c);
        a = '0;
        c = 0;
        while (a == 2'b00 && c < 10) begin
            @(posedge clk); #1;
            c++;
            a = bus.o_ack;
        end
    endtask

    task automatic run_vec(input vec_t v);
        int cycles;
        int we_cycles;
        logic seen;
        cycles = 0;
        we_cycles = 0;
        seen = 1'b0;
        @(negedge clk);
        set_req(v.k, 1'b1, v.we, 1'b0, v.off, v.wd);
        while (!seen && cycles < 10) begin
            @(posedge clk); #1;
            cycles++;
            if (bus.o_clint_we) begin
                we_cycles++;
                chk("vec_clint_off", 32'(bus.o_clint_offset), 32'(v.off));
                chk("vec_clint_wd", bus.o_clint_wdata, v.wd);
            end
            if (bus.o_ack != 2'b00) seen = 1'b1;
        end
        chk("vec_latency", cycles, 32'd2);
        chk("vec_ack", 32'(bus.o_ack), 32'(v.ack));
        chk("vec_rdata", bus.o_rdata, v.rd);
        chk("vec_we_cycles", we_cycles, 32'(v.we));
        set_req(v.k, 1'b0, 1'b0, 1'b0, 16'h0, 32'h0);
        @(posedge clk);
    endtask

    initial begin
        logic [1:0]  a;
        int          c;
        logic [31:0] mt;
        logic [1:0]  acks[4];
        int          cyc[4];
        int          n;
        int          ord[3];
        int          n0;
        logic [31:0] r1;

        vecs[0] = '{k:1, we:1'b1, off:16'h4000, wd:32'h0000_1234, ack:2'b10, rd:32'h0};
        vecs[1] = '{k:0, we:1'b0, off:16'h4000, wd:32'h0,         ack:2'b01, rd:32'h0000_1234};
        vecs[2] = '{k:0, we:1'b1, off:16'h0000, wd:32'h0000_0001, ack:2'b01, rd:32'h0};
        vecs[3] = '{k:1, we:1'b0, off:16'h0000, wd:32'h0,         ack:2'b10, rd:32'h0000_0001};
        vecs[4] = '{k:1, we:1'b1, off:16'h4004, wd:32'hABCD_0001, ack:2'b10, rd:32'h0};
        vecs[5] = '{k:0, we:1'b0, off:16'h4004, wd:32'h0,         ack:2'b01, rd:32'hABCD_0001};

        rst = 1'b1;
        bus.i_req = '0; bus.i_we = '0; bus.i_lock = '0;
        bus.i_offset = '0; bus.i_wdata = '0;
        #12;
        chk("rst_ack", 32'(bus.o_ack), 32'h0);
        chk("rst_busy", 32'(bus.o_busy), 32'h0);
        chk("rst_we", 32'(bus.o_clint_we), 32'h0);
        chk("rst_off", 32'(bus.o_clint_offset), 32'h0);
        chk("rst_rdata", bus.o_rdata, 32'h0);
        @(negedge clk) rst = 1'b0;

        for (int i = 0; i < 6; i++) run_vec(vecs[i]);

        // mtime read: rdata is the value registered on the ISSUE->RESP edge
        @(negedge clk);
        set_req(0, 1'b1, 1'b0, 1'b0, MTIME_LO, 32'h0);
        @(posedge clk); #1;
        mt = mtime[31:0];
        chk("mt_busy", 32'(bus.o_busy), 32'h1);
        chk("mt_we_issue", 32'(bus.o_clint_we), 32'h0);
        @(posedge clk); #1;
        chk("mt_ack", 32'(bus.o_ack), 32'h1);
        chk("mt_rdata", bus.o_rdata, mt + 32'd1);
        chk("mt_we_resp", 32'(bus.o_clint_we), 32'h0);
        set_req(0, 1'b0, 1'b0, 1'b0, 16'h0, 32'h0);
        @(posedge clk);

        // payload change after acceptance must not reach the port
        @(negedge clk);
        set_req(0, 1'b1, 1'b0, 1'b0, 16'h4000, 32'h0);
        @(posedge clk); #1;
        chk("pl_off_issue", 32'(bus.o_clint_offset), 32'h4000);
        set_req(0, 1'b1, 1'b0, 1'b0, MTIME_HI, 32'h0);
        @(posedge clk); #1;
        chk("pl_off_resp", 32'(bus.o_clint_offset), 32'h4000);
        chk("pl_ack", 32'(bus.o_ack), 32'h1);
        chk("pl_rdata", bus.o_rdata, 32'h0000_1234);
        set_req(0, 1'b0, 1'b0, 1'b0, 16'h0, 32'h0);
        @(posedge clk); #1;
        chk("idle_off_hold", 32'(bus.o_clint_offset), 32'h4000);
        chk("idle_ack", 32'(bus.o_ack), 32'h0);
        chk("idle_busy", 32'(bus.o_busy), 32'h0);

        // contention from reset: acks alternate, 3 cycles apart
        @(negedge clk);
        rst = 1'b1;
        set_req(0, 1'b1, 1'b0, 1'b0, MSIP_BASE, 32'h0);
        set_req(1, 1'b1, 1'b0, 1'b0, MSIP_BASE, 32'h0);
        @(negedge clk) rst = 1'b0;
        n = 0;
        for (int cy = 1; cy <= 12; cy++) begin
            @(posedge clk); #1;
            if (bus.o_ack != 2'b00 && n < 4) begin
                acks[n] = bus.o_ack;
                cyc[n]  = cy;
                n++;
            end
        end
        set_req(0, 1'b0, 1'b0, 1'b0, 16'h0, 32'h0);
        set_req(1, 1'b0, 1'b0, 1'b0, 16'h0, 32'h0);
        chk("cont_count", n, 32'd4);
        for (int i = 0; i < n; i++) begin
            chk("cont_ack", 32'(acks[i]), (i % 2 == 0) ? 32'h1 : 32'h2);
            chk("cont_cycle", cyc[i], 32'(2 + 3*i));
        end
        @(posedge clk);

        // reset during RESP: ack drops at once, pointer back to 0
        run_vec(vecs[1]);
        @(negedge clk);
        set_req(0, 1'b1, 1'b0, 1'b0, 16'h4000, 32'h0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("rm_pre_ack", 32'(bus.o_ack), 32'h1);
        #1 rst = 1'b1;
        #1;
        chk("rm_ack", 32'(bus.o_ack), 32'h0);
        chk("rm_busy", 32'(bus.o_busy), 32'h0);
        chk("rm_rdata", bus.o_rdata, 32'h0);
        set_req(0, 1'b1, 1'b0, 1'b0, MSIP_BASE, 32'h0);
        set_req(1, 1'b1, 1'b0, 1'b0, 16'h4004, 32'h0);
        @(negedge clk) rst = 1'b0;
        wait_ack(a, c);
        chk("rm_first_ack", 32'(a), 32'h1);
        chk("rm_first_lat", c, 32'd2);
        set_req(0, 1'b0, 1'b0, 1'b0, 16'h0, 32'h0);
        wait_ack(a, c);
        chk("rm_req1_ack", 32'(a), 32'h2);
        chk("rm_req1_lat", c, 32'd3);
        chk("rm_req1_rdata", bus.o_rdata, 32'hABCD_0001);
        set_req(1, 1'b0, 1'b0, 1'b0, 16'h0, 32'h0);
        @(posedge clk);

        // locked pair by req0 with req1 waiting
        @(negedge clk);
        set_req(0, 1'b1, 1'b1, 1'b1, 16'h4000, 32'h0000_0055);
        set_req(1, 1'b1, 1'b0, 1'b0, 16'h4000, 32'h0);
        n = 0; n0 = 0; r1 = 32'hFFFF_FFFF;
        for (int cy = 0; cy < 20 && n < 3; cy++) begin
            @(posedge clk); #1;
            if (bus.o_ack[0]) begin
                ord[n] = 0; n++; n0++;
                if (n0 == 1) set_req(0, 1'b1, 1'b1, 1'b0, 16'h4004, 32'h0000_0066);
                else         set_req(0, 1'b0, 1'b0, 1'b0, 16'h0, 32'h0);
            end else if (bus.o_ack[1]) begin
                ord[n] = 1; n++;
                r1 = bus.o_rdata;
                set_req(1, 1'b0, 1'b0, 1'b0, 16'h0, 32'h0);
            end
        end
        set_req(0, 1'b0, 1'b0, 1'b0, 16'h0, 32'h0);
        set_req(1, 1'b0, 1'b0, 1'b0, 16'h0, 32'h0);
        chk("lock_count", n, 32'd3);
        chk("lock_ord0", ord[0], 32'd0);
`ifdef CLINT_ARB_LOCK_EN
        chk("lock_ord1", ord[1], 32'd0);
        chk("lock_ord2", ord[2], 32'd1);
`else
        chk("lock_ord1", ord[1], 32'd1);
        chk("lock_ord2", ord[2], 32'd0);
`endif
        chk("lock_req1_rdata", r1, 32'h0000_0055);
        @(posedge clk);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
